denorm_seq: RTL and testbench

DENORM_SEQ -- requirements
Module: denorm_seq

---
 rtl/denorm_pkg.sv | 16 +
 rtl/denorm_shamt_calc.sv | 29 ++
 rtl/denorm_seq.sv | 116 +++++++++++
 tb/tb_denorm_seq.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/denorm_pkg.sv
// Shared constants and state type for the denormalization sequencer.
package denorm_pkg;

    localparam int FRAC_W  = 75;
    localparam int EXP_W   = 10;
    localparam int EMIN    = -126;
    localparam int MAX_SHF = 27;
    localparam int SHF_W   = 5;

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StDone
    } state_e;

endpackage

// File: rtl/denorm_shamt_calc.sv
// Derives the denormalization distance from the normalized exponent.
module denorm_shamt_calc
    import denorm_pkg::*;
(
    input  logic [EXP_W-1:0] exp_norm_i,
    output logic [EXP_W-1:0] diff_o,
    output logic             denorm_o,
    output logic [SHF_W-1:0] shamt_o
);

    logic signed [EXP_W-1:0] diff;
    logic                    sat;

    always_comb begin
        // Wraps at EXP_W bits; the sign of the wrapped value decides denormality.
        diff     = $signed(EXP_W'(EMIN)) - $signed(exp_norm_i);
        denorm_o = !diff[EXP_W-1] && (diff != '0);
        sat      = diff >= $signed(EXP_W'(MAX_SHF));
        if (!denorm_o) begin
            shamt_o = '0;
        end else if (sat) begin
            shamt_o = SHF_W'(MAX_SHF);
        end else begin
            shamt_o = diff[SHF_W-1:0];
        end
        diff_o = diff;
    end

endmodule

// File: rtl/denorm_seq.sv
// Multi-cycle denormalizing right shifter: IDLE accepts, SHIFT steps by STEP, DONE holds result.
module denorm_seq
    import denorm_pkg::*;
#(
    parameter int unsigned STEP = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [FRAC_W-1:0] frac_in,
    input  logic [EXP_W-1:0]  exp_norm,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [FRAC_W-1:0] frac_out,
    output logic              denorm_m,
    output logic              zero_m,
    output logic              busy
);

    localparam logic [SHF_W-1:0] StepAmt = SHF_W'(STEP);

    state_e            state_q, state_d;
    logic [FRAC_W-1:0] frac_q, frac_d;
    logic [SHF_W-1:0]  rem_q, rem_d;
    logic              denorm_q, denorm_d;
    logic              zero_q, zero_d;
    logic              big_q, big_d;

    logic [EXP_W-1:0]  diff;
    logic              denorm;
    logic [SHF_W-1:0]  shamt;
    logic              big;
    logic [SHF_W-1:0]  step_amt;

    denorm_shamt_calc u_shamt_calc (
        .exp_norm_i (exp_norm),
        .diff_o     (diff),
        .denorm_o   (denorm),
        .shamt_o    (shamt)
    );

    always_comb begin
        big      = $signed(diff) >= $signed(EXP_W'(MAX_SHF));
        step_amt = (rem_q < StepAmt) ? rem_q : StepAmt;
    end

    always_comb begin
        state_d  = state_q;
        frac_d   = frac_q;
        rem_d    = rem_q;
        denorm_d = denorm_q;
        zero_d   = zero_q;
        big_d    = big_q;
        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    frac_d   = frac_in;
                    rem_d    = shamt;
                    denorm_d = denorm;
                    big_d    = big;
                    if (shamt != '0) begin
                        state_d = StShift;
                        zero_d  = 1'b0;
                    end else begin
                        state_d = StDone;
                        zero_d  = (frac_in == '0);
                    end
                end
            end
            StShift: begin
                frac_d = frac_q >> step_amt;
                rem_d  = rem_q - step_amt;
                if (rem_d == '0) begin
                    state_d = StDone;
                    // Saturated shifts flush even if some bits survive the capped shift.
                    zero_d  = (frac_d == '0) || big_q;
                end
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            frac_q   <= '0;
            rem_q    <= '0;
            denorm_q <= 1'b0;
            zero_q   <= 1'b0;
            big_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            frac_q   <= frac_d;
            rem_q    <= rem_d;
            denorm_q <= denorm_d;
            zero_q   <= zero_d;
            big_q    <= big_d;
        end
    end

    always_comb begin
        in_ready  = (state_q == StIdle);
        out_valid = (state_q == StDone);
        busy      = (state_q == StShift) || (state_q == StDone);
        frac_out  = frac_q;
        denorm_m  = denorm_q;
        zero_m    = zero_q;
    end

endmodule

// File: tb/tb_denorm_seq.sv
// Self-checking bench for denorm_seq: directed vectors plus an arithmetic reference model.
module tb_denorm_seq;

    localparam int STEP = 8;
    localparam logic [74:0] ONE = 75'd1;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b1;
    logic [74:0] frac_in = '0;
    logic [9:0]  exp_norm = '0;
    logic        in_ready, out_valid, denorm_m, zero_m, busy;
    logic [74:0] frac_out;

    int     n_cmp = 0;
    int     n_err = 0;
    longint cyc = 0;

    typedef struct {
        logic [74:0] f;
        logic        d;
        logic        z;
        int          lat;
        longint      acc;
    } exp_t;

    exp_t exp_q[$];
    bit   seen = 1'b0;

    denorm_seq #(.STEP(STEP)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .frac_in   (frac_in),
        .exp_norm  (exp_norm),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .frac_out  (frac_out),
        .denorm_m  (denorm_m),
        .zero_m    (zero_m),
        .busy      (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [74:0] act, input logic [74:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: actual=%h required=%h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        n_cmp++;
        n_err++;
        $display("FAIL %s: timed out (cycle %0d)", name, cyc);
    endtask

    // Whole-operation view: one logical shift by the clamped distance.
    function automatic exp_t model(input logic [9:0] e, input logic [74:0] f);
        exp_t r;
        int   d;
        int   sh;
        d = -126 - int'($signed(e));
        if (d < -512) d += 1024;
        else if (d > 511) d -= 1024;
        sh    = (d <= 0) ? 0 : ((d > 27) ? 27 : d);
        r.f   = f >> sh;
        r.d   = (d > 0);
        r.z   = (r.f == '0) || (d >= 27);
        r.lat = (sh + STEP - 1) / STEP + 1;
        r.acc = 0;
        return r;
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            exp_q.delete();
            seen = 1'b0;
        end else begin
            check("ready_valid_excl", 75'(in_ready && out_valid), 75'(0));
            check("busy_vs_ready", 75'(busy), 75'(!in_ready));
            if (in_valid && in_ready) begin
                e     = model(exp_norm, frac_in);
                e.acc = cyc;
                exp_q.push_back(e);
            end
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    check("spurious_out_valid", 75'(out_valid), 75'(0));
                end else begin
                    e = exp_q[0];
                    check("model_frac", frac_out, e.f);
                    check("model_denorm", 75'(denorm_m), 75'(e.d));
                    check("model_zero", 75'(zero_m), 75'(e.z));
                    if (!seen) begin
                        check("model_latency", 75'(cyc - e.acc), 75'(e.lat));
                        seen = 1'b1;
                    end
                    if (out_ready) begin
                        void'(exp_q.pop_front());
                        seen = 1'b0;
                    end
                end
            end
        end
    end

    task automatic send(input logic [9:0] e, input logic [74:0] f);
        int k;
        k = 0;
        @(posedge clk);
        #1;
        while (!in_ready && k < 100) begin
            @(posedge clk);
            #1;
            k++;
        end
        if (!in_ready) fail_now("send_ready");
        exp_norm = e;
        frac_in  = f;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            lat++;
            if (out_valid) return;
        end
        fail_now("wait_valid");
        lat = -1;
    endtask

    task automatic run(input string name, input logic [9:0] e, input logic [74:0] f,
                       input logic [74:0] ef, input logic ed, input logic ez, input int elat);
        int lat;
        send(e, f);
        wait_valid(lat);
        check({name, "_frac"}, frac_out, ef);
        check({name, "_denorm"}, 75'(denorm_m), 75'(ed));
        check({name, "_zero"}, 75'(zero_m), 75'(ez));
        check({name, "_latency"}, 75'(lat), 75'(elat));
    endtask

    initial begin
        int lat;
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", 75'(in_ready), 75'(1));
        check("rst_out_valid", 75'(out_valid), 75'(0));
        check("rst_busy", 75'(busy), 75'(0));
        check("rst_frac", frac_out, 75'(0));
        check("rst_denorm", 75'(denorm_m), 75'(0));
        check("rst_zero", 75'(zero_m), 75'(0));
        rst = 1'b0;

        run("exp_m100", 10'h39C, ONE, ONE, 1'b0, 1'b0, 1);
        run("exp_m127", 10'h381, ONE << 74, ONE << 73, 1'b1, 1'b0, 2);
        run("exp_m150", 10'h36A, ONE << 74, ONE << 50, 1'b1, 1'b0, 4);
        run("exp_m126", 10'h382, 75'h123, 75'h123, 1'b0, 1'b0, 1);
        run("exp_m160", 10'h360, ONE << 74, ONE << 47, 1'b1, 1'b1, 5);
        run("exp_m140", 10'h374, 75'h3FF, 75'h0, 1'b1, 1'b1, 3);
        run("diff_27", 10'h367, ONE << 74, ONE << 47, 1'b1, 1'b1, 5);
        run("diff_26", 10'h368, ONE << 74, ONE << 48, 1'b1, 1'b0, 5);
        run("diff_9", 10'h379, ONE << 74, ONE << 65, 1'b1, 1'b0, 3);
        run("diff_8", 10'h37A, ONE << 74, ONE << 66, 1'b1, 1'b0, 2);
        run("wrap", 10'h1FF, ONE << 74, ONE << 47, 1'b1, 1'b1, 5);
        run("zero_in", 10'h005, 75'h0, 75'h0, 1'b0, 1'b1, 1);

        // Back-pressure: result must hold while out_ready is low; new operands ignored.
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        send(10'h381, ONE << 74);
        wait_valid(lat);
        check("bp_latency", 75'(lat), 75'(2));
        for (int i = 0; i < 3; i++) begin
            check("bp_valid", 75'(out_valid), 75'(1));
            check("bp_frac", frac_out, ONE << 73);
            check("bp_denorm", 75'(denorm_m), 75'(1));
            check("bp_zero", 75'(zero_m), 75'(0));
            check("bp_in_ready", 75'(in_ready), 75'(0));
            @(posedge clk);
            #1;
            in_valid = 1'b1;
            exp_norm = 10'h39C;
            frac_in  = 75'h5;
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_handoff_valid", 75'(out_valid), 75'(1));
        check("bp_handoff_frac", frac_out, ONE << 73);
        @(posedge clk);
        #1;
        check("bp_idle_ready", 75'(in_ready), 75'(1));
        check("bp_idle_valid", 75'(out_valid), 75'(0));

        // Reset during the second SHIFT cycle discards the operand.
        send(10'h36A, ONE << 74);
        @(posedge clk);
        #1;
        check("mid_shift_busy", 75'(busy), 75'(1));
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("mid_rst_in_ready", 75'(in_ready), 75'(1));
        check("mid_rst_out_valid", 75'(out_valid), 75'(0));
        check("mid_rst_busy", 75'(busy), 75'(0));
        check("mid_rst_frac", frac_out, 75'(0));
        check("mid_rst_denorm", 75'(denorm_m), 75'(0));
        check("mid_rst_zero", 75'(zero_m), 75'(0));
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("no_stale_result", 75'(out_valid), 75'(0));
        end

        // Reset wins over a simultaneous accept.
        @(posedge clk);
        #1;
        rst      = 1'b1;
        in_valid = 1'b1;
        exp_norm = 10'h381;
        frac_in  = ONE;
        @(posedge clk);
        #1;
        rst      = 1'b0;
        in_valid = 1'b0;
        check("rst_prio_busy", 75'(busy), 75'(0));
        check("rst_prio_frac", frac_out, 75'(0));

        run("after_rst", 10'h37A, 75'hFFFF, 75'hFF, 1'b1, 1'b0, 2);

        repeat (3) @(negedge clk);
        check("queue_drained", 75'(exp_q.size()), 75'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
